// File: rtl/req_grant_client.sv
`default_nettype none
// ============================================================================
//  Module   : req_grant_client
//  Purpose  : Requester-side companion to a fixed-priority one-hot selector.
//             Collects per-source request pulses into a pending vector that
//             feeds the selector, captures the returned one-hot grant, encodes
//             it to a binary index and offers it on a valid/ready handshake.
//             The serviced pending bit is cleared at capture time.
//  Ports    : clk         - clock, rising edge
//             rst         - asynchronous active-high reset
//             set_req     - per-source request pulses
//             req_out     - registered pending vector (selector input)
//             gnt_in      - one-hot grant from the selector
//             out_valid   - encoded grant available
//             out_idx     - binary index of granted source
//             out_ready   - downstream accepts current index
//             pending_cnt - popcount of the pending vector
//             err_gnt     - sticky grant-protocol error flag
//  Options  : REQ_GRANT_CLIENT_ERR_CHECK_EN - when defined, grants are checked
//             for legality (exactly one-hot, subset of req_out) and illegal
//             grants set the sticky err_gnt. When undefined, err_gnt is 0 and
//             any nonzero grant is captured via its lowest set bit.
//  Revision : 1.0 - initial release
// ============================================================================
module req_grant_client #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] set_req,
  output logic [NUM_REQ-1:0] req_out,
  input  logic [NUM_REQ-1:0] gnt_in,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  input  logic               out_ready,
  output logic [IDX_W:0]     pending_cnt,
  output logic               err_gnt
);

  localparam logic [NUM_REQ-1:0] C_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] r_pending;
  logic               r_out_valid;
  logic [IDX_W-1:0]   r_out_idx;

  logic               w_slot_free;
  logic               w_capture;
  logic [NUM_REQ-1:0] w_sel;
  logic [NUM_REQ-1:0] w_clr_mask;
  logic [NUM_REQ-1:0] w_pending_next;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W:0]     w_cnt;

  // The slot can take a new index if empty or being emptied this cycle.
  assign w_slot_free = ~r_out_valid | out_ready;

  // Isolate the lowest set grant bit. For a legal one-hot grant this is the
  // grant itself; without the legality check it defines which bit is served.
  assign w_sel = gnt_in & (~gnt_in + C_ONE);

`ifdef REQ_GRANT_CLIENT_ERR_CHECK_EN
  logic w_onehot;
  logic w_in_req;
  logic w_legal;
  logic w_illegal;
  logic r_err_gnt;

  assign w_onehot  = (gnt_in != '0) && ((gnt_in & (gnt_in - C_ONE)) == '0);
  assign w_in_req  = (gnt_in & ~r_pending) == '0;
  assign w_legal   = w_onehot & w_in_req;
  // An all-zero grant is a gated selector, not an error.
  assign w_illegal = (gnt_in != '0) & ~w_legal;
  assign w_capture = w_slot_free & w_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_gnt <= 1'b0;
    end else if (w_illegal) begin
      r_err_gnt <= 1'b1;
    end
  end

  assign err_gnt = r_err_gnt;
`else
  assign w_capture = w_slot_free & (gnt_in != '0);
  assign err_gnt   = 1'b0;
`endif

  assign w_clr_mask = w_capture ? w_sel : '0;

  // Set is applied after clear so a re-request during service re-arms.
  assign w_pending_next = (r_pending & ~w_clr_mask) | set_req;

  // w_sel has at most one bit set, so OR-ing indices is a plain encoder.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel[i]) begin
        w_idx = w_idx | IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cnt = w_cnt + {{IDX_W{1'b0}}, r_pending[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= w_idx;
      end else if (out_ready) begin
        // Drain; the index keeps its last value.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign req_out     = r_pending;
  assign out_valid   = r_out_valid;
  assign out_idx     = r_out_idx;
  assign pending_cnt = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_req_grant_client.sv
`default_nettype none
// ============================================================================
//  Module   : tb_req_grant_client
//  Purpose  : Self-checking bench for req_grant_client (NUM_REQ=4) with a
//             lowest-index-first selector between req_out and gnt_in, which
//             the stimulus can override to gate or corrupt the grant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_req_grant_client;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] set_req = 4'b0;
  logic [3:0] req_out;
  logic [3:0] gnt_in;
  logic       out_valid;
  logic [1:0] out_idx;
  logic       out_ready = 1'b0;
  logic [2:0] pending_cnt;
  logic       err_gnt;

  logic       force_en  = 1'b0;
  logic [3:0] force_val = 4'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int lowest_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] pick(input logic [3:0] v);
    int lo;
    lo = lowest_idx(v);
    return (lo < 0) ? 4'b0000 : (4'b0001 << lo);
  endfunction

  assign gnt_in = force_en ? force_val : pick(req_out);

  req_grant_client #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .set_req     (set_req),
    .req_out     (req_out),
    .gnt_in      (gnt_in),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_ready   (out_ready),
    .pending_cnt (pending_cnt),
    .err_gnt     (err_gnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, output slot and expected-index queue.
  logic [3:0] m_pend = 4'b0;
  logic [3:0] m_g;
  logic [3:0] m_clr;
  logic       m_valid = 1'b0;
  logic [1:0] m_idx = 2'b0;
  logic       m_err = 1'b0;
  logic       m_free;
  logic       m_cap;
  int         m_lo;
  int         exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend  = 4'b0;
      m_valid = 1'b0;
      m_idx   = 2'b0;
      m_err   = 1'b0;
      exp_q.delete();
    end else begin
      m_g    = force_en ? force_val : pick(m_pend);
      m_free = !m_valid || out_ready;
      m_lo   = lowest_idx(m_g);
`ifdef REQ_GRANT_CLIENT_ERR_CHECK_EN
      m_cap = m_free && ($countones(m_g) == 1) && ((m_g & ~m_pend) == 4'b0);
      if (m_g != 4'b0 && !(($countones(m_g) == 1) && ((m_g & ~m_pend) == 4'b0)))
        m_err = 1'b1;
`else
      m_cap = m_free && (m_g != 4'b0);
`endif
      if (m_valid && out_ready) m_valid = 1'b0;
      m_clr = 4'b0;
      if (m_cap) begin
        m_valid = 1'b1;
        m_idx   = 2'(m_lo);
        m_clr   = 4'b0001 << m_lo;
        exp_q.push_back(m_lo);
      end
      m_pend = (m_pend & ~m_clr) | set_req;
    end
  end

  // Monitor: compare visible state and score each accepted index.
  int popped;
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_out", req_out, m_pend);
      chk("pending_cnt", pending_cnt, $countones(m_pend));
      chk("out_valid", out_valid, m_valid);
      chk("err_gnt", err_gnt, m_err);
      if (m_valid) chk("out_idx", out_idx, m_idx);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept: got idx %0d expected no transfer at %0t", out_idx, $time);
        end else begin
          popped = exp_q.pop_front();
          chk("accepted_idx", out_idx, popped);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    set_req = v;
    cyc();
    set_req = 4'b0;
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Ordering: 0,1,3 back-to-back
    out_ready = 1'b1;
    pulse(4'b1011);
    cyc(6);

    // Backpressure: idx 1 held, then 1 and 2 drain
    out_ready = 1'b0;
    pulse(4'b0110);
    cyc(5);
    chk("stall_idx", out_idx, 2'd1);
    chk("stall_req_out", req_out, 4'b0100);
    out_ready = 1'b1;
    cyc(4);

    // Re-request while source 2 is being captured
    pulse(4'b0100);
    pulse(4'b0100);
    cyc(4);

    // Gated selector with bit 3 pending
    force_en  = 1'b1;
    force_val = 4'b0000;
    pulse(4'b1000);
    cyc(2);
    chk("gated_valid", out_valid, 1'b0);
    force_en = 1'b0;
    cyc(3);

    // Illegal multi-hot grant while req_out = 0011
    force_en  = 1'b1;
    force_val = 4'b0000;
    pulse(4'b0011);
    force_val = 4'b0011;
    cyc();
    force_en = 1'b0;
    cyc(5);

    // Randomized traffic, occasional gating and corrupt grants
    for (int n = 0; n < 400; n++) begin
      set_req   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 19))
        0: begin force_en = 1'b1; force_val = 4'b0; end
        1: begin force_en = 1'b1; force_val = 4'($urandom); end
        default: force_en = 1'b0;
      endcase
      cyc();
    end
    set_req   = 4'b0;
    force_en  = 1'b0;
    out_ready = 1'b1;
    cyc(8);

    // Asynchronous reset mid-stall with pending = 1010
    out_ready = 1'b0;
    pulse(4'b1010);
    cyc();
    pulse(4'b0010);
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_req_out", req_out, 4'b1010);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_out", req_out, 4'b0);
    chk("rst_pending_cnt", pending_cnt, 3'd0);
    chk("rst_out_idx", out_idx, 2'd0);
    chk("rst_err_gnt", err_gnt, 1'b0);
    set_req = 4'b1111;
    cyc(2);
    chk("in_rst_req_out", req_out, 4'b0);
    chk("in_rst_valid", out_valid, 1'b0);
    set_req = 4'b0;
    rst = 1'b0;
    cyc(2);

    // Post-reset ordering again, then drain
    out_ready = 1'b1;
    pulse(4'b1101);
    cyc(6);
    chk("drain_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/req_grant_client.md
Name: req_grant_client

Overview:
- Requester-side companion to the team's fixed-priority one-hot selector.
- Accumulates per-source request pulses into a pending vector, which drives the selector's input.
- Takes the one-hot grant back from the selector, encodes it to a binary index, and presents it downstream on a valid/ready handshake.
- Clears the serviced pending bit at capture, so the next-lowest source wins on the following cycle.

Parameters:
- NUM_REQ, 4: number of request sources; must be at least 2.
- IDX_W, $clog2(NUM_REQ): width of the encoded index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- set_req  in  NUM_REQ  per-source request pulses, sampled every cycle.
- req_out  out  NUM_REQ  pending vector; drives the selector input.
- gnt_in  in  NUM_REQ  one-hot grant from the selector; combinational function of req_out.
- out_valid  out  1  encoded grant is available.
- out_idx  out  IDX_W  binary index of the granted source.
- out_ready  in  1  downstream accepts the current index.
- pending_cnt  out  IDX_W+1  number of set bits in the pending register.
- err_gnt  out  1  sticky grant-protocol error flag.

Behaviour:
- Reset (async assert, sync deassert at the clk edge):
  - pending = 0, out_valid = 0, out_idx = 0, err_gnt = 0.
  - An in-flight index is dropped. No further state changes while rst is high.
- req_out equals the pending register directly (registered, glitch-free).
- pending_cnt is the popcount of the pending register.
  - Combinational from the register; range 0..NUM_REQ, no overflow at that width.
- Slot free = !out_valid | (out_valid & out_ready).
- Grant is legal when gnt_in is exactly one-hot and gnt_in & ~req_out == 0.
- Capture happens when the slot is free and a legal grant is present:
  - out_idx <= encode(gnt_in); out_valid <= 1.
  - The granted bit is cleared in pending.
  - Latency: a request pulse in cycle N appears on req_out in cycle N+1. If selected, out_valid rises in cycle N+2.
- Drain: out_valid & out_ready with no capture gives out_valid <= 0. out_idx holds its last value.
- Back-to-back: with out_ready held high, one index is issued per cycle while any bit is pending.
- Stall: while out_valid & !out_ready, out_idx and out_valid hold stable and no capture occurs. pending still accepts new set_req.
- Pending update: pending_next = (pending & ~clr_mask) | set_req.
  - Set wins over the same-cycle clear of the same bit: a re-request during service is re-armed.
  - A set_req on an already pending bit is merged, not counted.
- gnt_in == 0 with pending != 0: no capture, no error (selector may be gated externally).
- Illegal grant (multi-hot, or a bit not in req_out):
  - No capture; pending is unchanged by clear.
  - err_gnt <= 1 and stays set until rst.
- Wrap-around: none; the index range is fixed at 0..NUM_REQ-1. Non-power-of-2 NUM_REQ is supported.

Optional Feature:
- Macro: REQ_GRANT_CLIENT_ERR_CHECK_EN.
- Defined: the grant legality check and the sticky err_gnt register are built as described above.
- Undefined:
  - err_gnt is tied to 0.
  - Any nonzero gnt_in with a free slot is captured, using the lowest set bit of gnt_in.
  - That bit is cleared in pending.

Test Plan (NUM_REQ=4, bench wires a fixed-priority lowest-index-first selector between req_out and gnt_in):
- Reset check: assert rst mid-stall with out_valid=1 and pending=4'b1010. Required: out_valid=0, req_out=0, pending_cnt=0, out_idx=0 immediately (async), and no capture until after deassert.
- Ordering: set_req=4'b1011 for one cycle, out_ready=1. Required: out_idx=0,1,3 on three consecutive cycles, then out_valid=0 and pending_cnt 3→2→1→0.
- Backpressure: set_req=4'b0110, out_ready=0 for 5 cycles. Required: out_valid=1 and out_idx=1 held stable, req_out=4'b0100. On raising out_ready: idx 1 is accepted, then idx 2 the next cycle.
- Re-request: with source 2 being captured this cycle, pulse set_req=4'b0100 in the same cycle. Required: pending bit 2 stays set and idx 2 is issued a second time.
- Error (macro defined): force gnt_in=4'b0011 while req_out=4'b0011. Required: no capture, err_gnt=1 sticky, pending unchanged. With the macro undefined: out_idx=0 and err_gnt=0.
- Gated selector: force gnt_in=0 for 3 cycles with pending=4'b1000. Required: out_valid stays 0 and err_gnt=0. On release, out_idx=3.
